// File: rtl/riscv_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: stage enables/flushes, load-use stall,
// branch redirect, EX forwarding select and multi-cycle EX start/done handshake.
//   state       | meaning
//   ST_RUN      | normal issue, checks multi-cycle start and load-use
//   ST_MC_WAIT  | IF..EX frozen until the multi-cycle unit pulses done
//   ST_REDIRECT | squash the one stale fetch left behind by a taken redirect
module riscv_hazard_ctrl #(
    parameter int REGFILE_COUNT = 32,
    parameter int CNT_W         = 16,
    localparam int RW           = $clog2(REGFILE_COUNT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [RW-1:0]    id_rs0_i,
    input  logic [RW-1:0]    id_rs1_i,
    input  logic             id_rs0_used_i,
    input  logic             id_rs1_used_i,
    input  logic [RW-1:0]    id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_multi_i,
    input  logic             PC_src_i,
    input  logic             ex_done_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic [1:0]       fwd0_sel_o,
    output logic [1:0]       fwd1_sel_o,
    output logic             ex_start_o,
    output logic             ex_abort_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {ST_RUN, ST_MC_WAIT, ST_REDIRECT} state_e;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          mem_read;
        logic          multi;
        logic [RW-1:0] rs0;
        logic [RW-1:0] rs1;
        logic          rs0_used;
        logic          rs1_used;
    } ex_ent_t;

    // Past EX only the destination matters, for forwarding.
    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          reg_write;
    } dst_ent_t;

    state_e     state_q, state_d;
    ex_ent_t    ex_q, ex_d, id_ent;
    dst_ent_t   mem_q, mem_d, wb_q, wb_d, ex_dst;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, redirect_cnt_q, redirect_cnt_d;
    logic       load_use;

    function automatic logic hits(input dst_ent_t e, input logic [RW-1:0] rs);
        hits = e.valid & e.reg_write & (e.rd != '0) & (e.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [RW-1:0] rs,
                                           input dst_ent_t mem, input dst_ent_t wb);
        fwd_sel = 2'b00;
        if (used && hits(mem, rs))
            fwd_sel = 2'b01;
        else if (used && hits(wb, rs))
            fwd_sel = 2'b10;
    endfunction

    always_comb begin
        id_ent.valid     = id_valid_i;
        id_ent.rd        = id_rd_i;
        id_ent.reg_write = id_reg_write_i;
        id_ent.mem_read  = id_mem_read_i;
        id_ent.multi     = id_multi_i;
        id_ent.rs0       = id_rs0_i;
        id_ent.rs1       = id_rs1_i;
        id_ent.rs0_used  = id_rs0_used_i;
        id_ent.rs1_used  = id_rs1_used_i;

        ex_dst.valid     = ex_q.valid;
        ex_dst.rd        = ex_q.rd;
        ex_dst.reg_write = ex_q.reg_write;
    end

    assign load_use = id_valid_i & ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd != '0) &
                      ((id_rs0_used_i & (id_rs0_i == ex_q.rd)) |
                       (id_rs1_used_i & (id_rs1_i == ex_q.rd)));

    assign fwd0_sel_o = fwd_sel(ex_q.valid & ex_q.rs0_used, ex_q.rs0, mem_q, wb_q);
    assign fwd1_sel_o = fwd_sel(ex_q.valid & ex_q.rs1_used, ex_q.rs1, mem_q, wb_q);

    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        ex_start_o     = 1'b0;
        ex_abort_o     = 1'b0;
        state_d        = state_q;
        ex_d           = id_ent;
        mem_d          = ex_dst;
        wb_d           = mem_q;
        redirect_cnt_d = redirect_cnt_q;

        // Outputs stay at their idle values for as long as reset is held.
        if (!rst_i) begin
            if (PC_src_i) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                ex_abort_o     = (state_q == ST_MC_WAIT);
                ex_d           = '0;
                mem_d          = '0;
                state_d        = ST_REDIRECT;
                if (redirect_cnt_q != '1)
                    redirect_cnt_d = redirect_cnt_q + 1'b1;
            end else begin
                case (state_q)
                    ST_REDIRECT: begin
                        if_id_flush_o = 1'b1;
                        state_d       = ST_RUN;
                    end
                    ST_MC_WAIT: begin
                        if (!ex_done_i) begin
                            pc_en_o        = 1'b0;
                            if_id_en_o     = 1'b0;
                            id_ex_en_o     = 1'b0;
                            ex_mem_flush_o = 1'b1;
                            ex_d           = ex_q;
                            mem_d          = '0;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                        if (ex_q.valid && ex_q.multi) begin
                            ex_start_o     = 1'b1;
                            pc_en_o        = 1'b0;
                            if_id_en_o     = 1'b0;
                            id_ex_en_o     = 1'b0;
                            ex_mem_flush_o = 1'b1;
                            ex_d           = ex_q;
                            mem_d          = '0;
                            state_d        = ST_MC_WAIT;
                        end else if (load_use) begin
                            pc_en_o       = 1'b0;
                            if_id_en_o    = 1'b0;
                            id_ex_flush_o = 1'b1;
                            ex_d          = '0;
                        end
                    end
                endcase
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en_o && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            ex_q           <= '0;
            mem_q          <= '0;
            wb_q           <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            ex_q           <= ex_d;
            mem_q          <= mem_d;
            wb_q           <= wb_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;

endmodule
